// File: rtl/fp_accum_seq.sv
// Running-sum sequencer in front of a multi-cycle single-precision adder.
// Elements arrive on a valid/ready port; the sum is presented after the element flagged last.
module fp_accum_seq #(
    parameter logic [31:0] ACC_INIT = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             add_start,
    output logic [31:0]      add_op_a,
    output logic [31:0]      add_op_b,
    input  logic [31:0]      add_res,
    input  logic             add_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   count;
    logic [31:0]        op_b_r;
    logic               last_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= ACC_INIT;
            count  <= '0;
            last_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        last_r <= in_last;
                    end
                end
                WAIT_DONE: begin
                    if (add_done) begin
                        acc   <= add_res;
                        count <= sat_inc(count);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc   <= ACC_INIT;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand B is pure data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_b_r <= in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        add_start = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_start = 1'b1;
                if (add_done) state_nxt = WAIT_ACK;
            end
            // add_done is still high from the idle adder on this cycle; skip it.
            WAIT_ACK: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (add_done) state_nxt = last_r ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign add_op_a  = acc;
    assign add_op_b  = op_b_r;
    assign out_data  = acc;
    assign out_count = count;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a behavioural variable-latency adder model.
module tb_fp_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        add_start;
    logic [31:0] add_op_a;
    logic [31:0] add_op_b;
    logic [31:0] add_res;
    logic        add_done;

    int total = 0;
    int bad   = 0;

    fp_accum_seq #(.ACC_INIT(32'h00000000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .add_start(add_start), .add_op_a(add_op_a), .add_op_b(add_op_b),
        .add_res(add_res), .add_done(add_done)
    );

    always #5 clk = ~clk;

    // Hand-computed single-precision sums for the operand pairs used below.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h3F800000}: return 32'h3F800000;
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h3F000000}: return 32'h40600000;
            {32'h00000000, 32'h40A00000}: return 32'h40A00000;
            {32'h40A00000, 32'hC0A00000}: return 32'h00000000;
            {32'h00000000, 32'hBF800000}: return 32'hBF800000;
            {32'h00000000, 32'h7F800000}: return 32'h7F800000;
            {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
            {32'h00000000, 32'h40000000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Adder model: not reset with the sequencer; force_busy holds add_done low.
    logic        done_r     = 1'b1;
    logic        busy       = 1'b0;
    logic        force_busy = 1'b0;
    int          lat        = 2;
    int          cnt        = 0;
    int          starts     = 0;
    int          start_cyc  = 0;
    logic [31:0] res_r      = 32'h0;

    assign add_done = done_r & ~force_busy;
    assign add_res  = res_r;

    always @(posedge clk) begin
        if (add_start) start_cyc <= start_cyc + 1;
        if (busy) begin
            if (cnt == 0) begin
                busy   <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (add_start && add_done) begin
            busy   <= 1'b1;
            done_r <= 1'b0;
            cnt    <= lat;
            res_r  <= fadd(add_op_a, add_op_b);
            starts <= starts + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_ready_timeout", {31'h0, ok}, 32'h1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("out_valid_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_d, input logic [15:0] exp_c);
        wait_out();
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_count"}, {16'h0, out_count}, {16'h0, exp_c});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int s0;
        int c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_add_start", {31'h0, add_start}, 32'h0);
        chk("rst_count", {16'h0, out_count}, 32'h0);
        chk("rst_acc", out_data, 32'h0);

        // Sum of three: 1.0 + 2.0 + 0.5 = 3.5
        s0 = starts;
        c0 = start_cyc;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h3F000000, 1'b1);
        get_result("sum3", 32'h40600000, 16'd3);
        chk("sum3_starts", starts - s0, 32'd3);
        chk("sum3_start_cycles", start_cyc - c0, 32'd3);

        // Cancellation: 5.0 + -5.0
        send(32'h40A00000, 1'b0);
        send(32'hC0A00000, 1'b1);
        get_result("cancel", 32'h00000000, 16'd2);

        // Single element, then the accumulator must be back at +0.0
        send(32'hBF800000, 1'b1);
        get_result("single", 32'hBF800000, 16'd1);
        chk("single_acc_cleared", out_data, 32'h00000000);
        chk("single_count_cleared", {16'h0, out_count}, 32'h0);

        // Backpressure: hold the sum for 10 cycles
        lat = 4;
        send(32'h3F800000, 1'b1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_data", out_data, 32'h3F800000);
            chk("bp_count", {16'h0, out_count}, 32'h1);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        get_result("bp", 32'h3F800000, 16'd1);

        // Busy adder during ISSUE, Inf + 1.0 = Inf
        lat = 1;
        force_busy = 1'b1;
        s0 = starts;
        send(32'h7F800000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("busy_start_held", {31'h0, add_start}, 32'h1);
            chk("busy_op_a", add_op_a, 32'h00000000);
            chk("busy_op_b", add_op_b, 32'h7F800000);
            @(negedge clk);
        end
        chk("busy_no_accept", starts - s0, 32'd0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("busy_accepted", starts - s0, 32'd1);
        chk("busy_start_dropped", {31'h0, add_start}, 32'h0);
        send(32'h3F800000, 1'b1);
        get_result("inf", 32'h7F800000, 16'd2);

        // Reset in WAIT_DONE of the second element; adder keeps running
        lat = 3;
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_last  = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_add_start", {31'h0, add_start}, 32'h0);
        chk("mid_rst_acc", out_data, 32'h00000000);
        send(32'h3F800000, 1'b1);
        get_result("after_rst", 32'h3F800000, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
